// File: rtl/fetch_buffer_if.sv
// Front-end bundle between if_stage, fetch_buffer and decode.
// The slave modport is the buffer's view; the master modport drives it.
interface fetch_buffer_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   if_IRA_out, if_IRB_out;
  logic [63:0]   if_PCA_out, if_PCB_out;
  logic [63:0]   if_NPCA_out, if_NPCB_out;
  logic          branch_predictionA, branch_predictionB;
  logic          if_valid_instA_out, if_valid_instB_out;
  logic          mispredict_branchA, mispredict_branchB;
  logic          non_ins_en_in, one_ins_en_in;

  logic [31:0]   fb_IRA_out, fb_IRB_out;
  logic [63:0]   fb_PCA_out, fb_PCB_out;
  logic [63:0]   fb_NPCA_out, fb_NPCB_out;
  logic          fb_bpA_out, fb_bpB_out;
  logic          fb_valid_instA_out, fb_valid_instB_out;
  logic          fb_full, fb_almost_full;
  logic [CW-1:0] fb_count;

  modport slave (
    input  if_IRA_out, if_IRB_out, if_PCA_out, if_PCB_out,
           if_NPCA_out, if_NPCB_out, branch_predictionA, branch_predictionB,
           if_valid_instA_out, if_valid_instB_out,
           mispredict_branchA, mispredict_branchB,
           non_ins_en_in, one_ins_en_in,
    output fb_IRA_out, fb_IRB_out, fb_PCA_out, fb_PCB_out,
           fb_NPCA_out, fb_NPCB_out, fb_bpA_out, fb_bpB_out,
           fb_valid_instA_out, fb_valid_instB_out,
           fb_full, fb_almost_full, fb_count
  );

  modport master (
    output if_IRA_out, if_IRB_out, if_PCA_out, if_PCB_out,
           if_NPCA_out, if_NPCB_out, branch_predictionA, branch_predictionB,
           if_valid_instA_out, if_valid_instB_out,
           mispredict_branchA, mispredict_branchB,
           non_ins_en_in, one_ins_en_in,
    input  fb_IRA_out, fb_IRB_out, fb_PCA_out, fb_PCB_out,
           fb_NPCA_out, fb_NPCB_out, fb_bpA_out, fb_bpB_out,
           fb_valid_instA_out, fb_valid_instB_out,
           fb_full, fb_almost_full, fb_count
  );
endinterface

// File: rtl/fetch_buffer.sv
// 2-in / 2-out circular instruction queue between fetch and decode.
// Flushes on mispredict; outputs are the two oldest entries, never bypassed.
module fetch_buffer #(
  parameter int DEPTH = 8
) (
  input logic           clock,
  input logic           reset,
  fetch_buffer_if.slave fb_if
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   ir_q  [DEPTH];
  logic [63:0]   pc_q  [DEPTH];
  logic [63:0]   npc_q [DEPTH];
  logic          bp_q  [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;

  logic          flush, full;
  logic          wr_a, wr_b;
  logic [AW-1:0] wr_b_idx, head_nx;
  logic [CW-1:0] enq, deq, req;
  logic          out_va, out_vb;

  assign flush = fb_if.mispredict_branchA | fb_if.mispredict_branchB;
  assign full  = count > CW'(DEPTH - 2);

  always_comb begin
    wr_a     = ~full & fb_if.if_valid_instA_out;
    wr_b     = ~full & fb_if.if_valid_instB_out;
    // B lands right after A, or at tail itself when A is empty
    wr_b_idx = tail + AW'(wr_a);
    enq      = CW'(wr_a) + CW'(wr_b);
    if (fb_if.non_ins_en_in)      req = CW'(0);
    else if (fb_if.one_ins_en_in) req = CW'(1);
    else                          req = CW'(2);
    deq      = (req < count) ? req : count;
    head_nx  = head + AW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ir_q[i]  <= '0;
        pc_q[i]  <= '0;
        npc_q[i] <= '0;
        bp_q[i]  <= 1'b0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_a) begin
        ir_q[tail]  <= fb_if.if_IRA_out;
        pc_q[tail]  <= fb_if.if_PCA_out;
        npc_q[tail] <= fb_if.if_NPCA_out;
        bp_q[tail]  <= fb_if.branch_predictionA;
      end
      if (wr_b) begin
        ir_q[wr_b_idx]  <= fb_if.if_IRB_out;
        pc_q[wr_b_idx]  <= fb_if.if_PCB_out;
        npc_q[wr_b_idx] <= fb_if.if_NPCB_out;
        bp_q[wr_b_idx]  <= fb_if.branch_predictionB;
      end
      tail  <= tail + AW'(enq);
      head  <= head + AW'(deq);
      count <= count + enq - deq;
    end
  end

  always_comb begin
    out_va = (count >= CW'(1)) & ~flush;
    out_vb = (count >= CW'(2)) & ~flush;
    fb_if.fb_valid_instA_out = out_va;
    fb_if.fb_valid_instB_out = out_vb;
    fb_if.fb_IRA_out  = out_va ? ir_q[head]     : '0;
    fb_if.fb_PCA_out  = out_va ? pc_q[head]     : '0;
    fb_if.fb_NPCA_out = out_va ? npc_q[head]    : '0;
    fb_if.fb_bpA_out  = out_va ? bp_q[head]     : 1'b0;
    fb_if.fb_IRB_out  = out_vb ? ir_q[head_nx]  : '0;
    fb_if.fb_PCB_out  = out_vb ? pc_q[head_nx]  : '0;
    fb_if.fb_NPCB_out = out_vb ? npc_q[head_nx] : '0;
    fb_if.fb_bpB_out  = out_vb ? bp_q[head_nx]  : 1'b0;
    fb_if.fb_full        = full;
    fb_if.fb_almost_full = count > CW'(DEPTH - 4);
    fb_if.fb_count       = count;
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer (DEPTH=8) with hand-computed expectations.
module tb_fetch_buffer;
  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  fetch_buffer_if #(.DEPTH(8)) bus ();
  fetch_buffer #(.DEPTH(8)) dut (.clock(clock), .reset(reset), .fb_if(bus));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // IR = PC + 0x1000, NPC = PC + 4, bp = PC bit 2
  task automatic drive(input logic va, input logic [63:0] pca,
                       input logic vb, input logic [63:0] pcb);
    bus.if_valid_instA_out = va;
    bus.if_PCA_out  = pca;
    bus.if_IRA_out  = pca[31:0] + 32'h1000;
    bus.if_NPCA_out = pca + 64'd4;
    bus.branch_predictionA = pca[2];
    bus.if_valid_instB_out = vb;
    bus.if_PCB_out  = pcb;
    bus.if_IRB_out  = pcb[31:0] + 32'h1000;
    bus.if_NPCB_out = pcb + 64'd4;
    bus.branch_predictionB = pcb[2];
  endtask

  task automatic deq_ctl(input logic non, input logic one);
    bus.non_ins_en_in = non;
    bus.one_ins_en_in = one;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 64'h0, 1'b0, 64'h0);
    deq_ctl(1'b1, 1'b0);
    bus.mispredict_branchA = 1'b0;
    bus.mispredict_branchB = 1'b0;
    #2;
    step(); step();

    // reset state
    chk("rst_count", 64'(bus.fb_count), 64'd0);
    chk("rst_vA", 64'(bus.fb_valid_instA_out), 64'd0);
    chk("rst_vB", 64'(bus.fb_valid_instB_out), 64'd0);
    chk("rst_full", 64'(bus.fb_full), 64'd0);
    chk("rst_afull", 64'(bus.fb_almost_full), 64'd0);
    chk("rst_IRA", 64'(bus.fb_IRA_out), 64'd0);
    chk("rst_PCB", bus.fb_PCB_out, 64'd0);

    // basic pair enqueue with no dequeue
    reset = 1'b0;
    drive(1'b1, 64'h0, 1'b1, 64'h4);
    bus.if_IRA_out = 32'h11111111;
    bus.if_IRB_out = 32'h22222222;
    step();
    drive(1'b0, 64'h0, 1'b0, 64'h0);
    chk("t1_count", 64'(bus.fb_count), 64'd2);
    chk("t1_vA", 64'(bus.fb_valid_instA_out), 64'd1);
    chk("t1_vB", 64'(bus.fb_valid_instB_out), 64'd1);
    chk("t1_IRA", 64'(bus.fb_IRA_out), 64'h11111111);
    chk("t1_IRB", 64'(bus.fb_IRB_out), 64'h22222222);
    chk("t1_PCB", bus.fb_PCB_out, 64'h4);
    chk("t1_NPCA", bus.fb_NPCA_out, 64'h4);
    chk("t1_bpB", 64'(bus.fb_bpB_out), 64'd1);

    // fill to full
    reset = 1'b1; step(); reset = 1'b0;
    drive(1'b1, 64'h0,  1'b1, 64'h4);  step();
    drive(1'b1, 64'h8,  1'b1, 64'hC);  step();
    drive(1'b1, 64'h10, 1'b1, 64'h14); step();
    chk("fill3_count", 64'(bus.fb_count), 64'd6);
    chk("fill3_afull", 64'(bus.fb_almost_full), 64'd1);
    chk("fill3_full", 64'(bus.fb_full), 64'd0);
    drive(1'b1, 64'h18, 1'b1, 64'h1C); step();
    chk("fill4_count", 64'(bus.fb_count), 64'd8);
    chk("fill4_full", 64'(bus.fb_full), 64'd1);
    drive(1'b1, 64'h20, 1'b1, 64'h24); step();
    drive(1'b0, 64'h0, 1'b0, 64'h0);
    chk("fill5_count", 64'(bus.fb_count), 64'd8);
    chk("fill5_PCA", bus.fb_PCA_out, 64'h0);
    chk("fill5_PCB", bus.fb_PCB_out, 64'h4);

    // partial dequeue: head advances by one
    reset = 1'b1; step(); reset = 1'b0;
    drive(1'b1, 64'h0, 1'b1, 64'h4); step();
    drive(1'b1, 64'h8, 1'b0, 64'h0); step();
    drive(1'b0, 64'h0, 1'b0, 64'h0);
    chk("pd_pre_count", 64'(bus.fb_count), 64'd3);
    deq_ctl(1'b0, 1'b1); step(); deq_ctl(1'b1, 1'b0);
    chk("pd_PCA", bus.fb_PCA_out, 64'h4);
    chk("pd_PCB", bus.fb_PCB_out, 64'h8);
    chk("pd_count", 64'(bus.fb_count), 64'd2);

    // head=1, tail=3; grow to 6 entries at indices 1..6
    drive(1'b1, 64'hC,  1'b1, 64'h10); step();
    drive(1'b1, 64'h14, 1'b1, 64'h18); step();
    chk("wr_pre_count", 64'(bus.fb_count), 64'd6);
    // enq 2 at tail=7 (wraps to 0) while dequeuing 2
    drive(1'b1, 64'h1C, 1'b1, 64'h20);
    deq_ctl(1'b0, 1'b0);
    step();
    drive(1'b0, 64'h0, 1'b0, 64'h0);
    chk("wr_count", 64'(bus.fb_count), 64'd6);
    chk("wr_PCA", bus.fb_PCA_out, 64'hC);
    step();
    chk("wr2_PCA", bus.fb_PCA_out, 64'h14);
    chk("wr2_count", 64'(bus.fb_count), 64'd4);
    step();
    deq_ctl(1'b1, 1'b0);
    chk("wr3_PCA", bus.fb_PCA_out, 64'h1C);
    chk("wr3_PCB", bus.fb_PCB_out, 64'h20);
    chk("wr3_IRB", 64'(bus.fb_IRB_out), 64'h1020);
    chk("wr3_NPCA", bus.fb_NPCA_out, 64'h20);
    // non wins over one
    deq_ctl(1'b1, 1'b1); step();
    chk("prio_count", 64'(bus.fb_count), 64'd2);
    deq_ctl(1'b0, 1'b0); step(); deq_ctl(1'b1, 1'b0);
    chk("drain_count", 64'(bus.fb_count), 64'd0);
    chk("drain_vA", 64'(bus.fb_valid_instA_out), 64'd0);
    chk("drain_PCA", bus.fb_PCA_out, 64'h0);

    // only B valid, no same-cycle bypass
    drive(1'b0, 64'h0, 1'b1, 64'h14);
    #1;
    chk("nb_vA", 64'(bus.fb_valid_instA_out), 64'd0);
    step();
    drive(1'b0, 64'h0, 1'b0, 64'h0);
    chk("ob_PCA", bus.fb_PCA_out, 64'h14);
    chk("ob_vB", 64'(bus.fb_valid_instB_out), 64'd0);
    chk("ob_count", 64'(bus.fb_count), 64'd1);

    // flush with 5 entries and an incoming pair
    drive(1'b1, 64'h18, 1'b1, 64'h1C); step();
    drive(1'b1, 64'h20, 1'b1, 64'h24); step();
    chk("fl_pre_count", 64'(bus.fb_count), 64'd5);
    drive(1'b1, 64'h30, 1'b1, 64'h34);
    deq_ctl(1'b0, 1'b0);
    bus.mispredict_branchA = 1'b1;
    #1;
    chk("fl_vA", 64'(bus.fb_valid_instA_out), 64'd0);
    chk("fl_vB", 64'(bus.fb_valid_instB_out), 64'd0);
    step();
    bus.mispredict_branchA = 1'b0;
    deq_ctl(1'b1, 1'b0);
    drive(1'b0, 64'h0, 1'b0, 64'h0);
    chk("fl_count", 64'(bus.fb_count), 64'd0);
    chk("fl_full", 64'(bus.fb_full), 64'd0);
    drive(1'b1, 64'h14, 1'b0, 64'h0); step();
    drive(1'b0, 64'h0, 1'b0, 64'h0);
    chk("pf_PCA", bus.fb_PCA_out, 64'h14);
    chk("pf_count", 64'(bus.fb_count), 64'd1);

    // mispredictB flushes too
    bus.mispredict_branchB = 1'b1; step(); bus.mispredict_branchB = 1'b0;
    chk("flB_count", 64'(bus.fb_count), 64'd0);

    // reset mid-operation beats a concurrent enqueue
    drive(1'b1, 64'h40, 1'b1, 64'h44); step();
    reset = 1'b1;
    drive(1'b1, 64'h48, 1'b1, 64'h4C);
    step();
    reset = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 64'h0);
    chk("mr_count", 64'(bus.fb_count), 64'd0);
    chk("mr_PCA", bus.fb_PCA_out, 64'h0);
    chk("mr_vA", 64'(bus.fb_valid_instA_out), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
